// File: rtl/window_stream_arbiter.sv
// Packet-aware round-robin arbiter: LEVELS window streams onto one bus.
// Grant is held for BEATS beats so serialized windows never interleave.
//
// Ports:
//   clk, rst_n          fast clock, async active-low reset
//   in_valid/in_ready   per-level handshake (LEVELS bits)
//   in_stream           per-level beats, level j at [j*BUS_WIDTH +: BUS_WIDTH]
//   out_valid/out_ready registered output handshake
//   out_stream          output beat
//   out_level           source level of out_stream
//   out_last            final beat of a window packet
//   grant               one-hot owner, zero when idle
//   busy                high while a packet is in progress
module window_stream_arbiter #(
    parameter int BUS_WIDTH = 128,
    parameter int LEVELS    = 7,
    parameter int LEVEL_W   = 3,
    parameter int BEATS     = 10,
    parameter int CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LEVELS-1:0]           in_valid,
    input  logic [BUS_WIDTH*LEVELS-1:0] in_stream,
    output logic [LEVELS-1:0]           in_ready,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_stream,
    output logic [LEVEL_W-1:0]          out_level,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [LEVELS-1:0]           grant,
    output logic                        busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LEVEL_W-1:0]   rr_ptr;
    logic [LEVEL_W-1:0]   gidx;
    logic [LEVEL_W-1:0]   sel;
    logic [LEVEL_W-1:0]   cand;
    logic                 sel_hit;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 out_free;
    logic                 xfer;
    logic                 is_last;
    logic [BUS_WIDTH-1:0] beat;
    int                   sk;

    // Scan downward so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        sel     = '0;
        sel_hit = 1'b0;
        sk      = 0;
        cand    = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            sk = int'(rr_ptr) + i;
            if (sk >= LEVELS) begin
                sk = sk - LEVELS;
            end
            cand = LEVEL_W'(sk);
            if (in_valid[cand]) begin
                sel     = cand;
                sel_hit = 1'b1;
            end
        end
    end

    assign busy     = (state == BURST);
    assign out_free = ~out_valid | out_ready;
    assign beat     = in_stream[int'(gidx)*BUS_WIDTH +: BUS_WIDTH];
    assign xfer     = busy & in_valid[gidx] & out_free;
    assign is_last  = (beat_cnt == CNT_W'(BEATS - 1));

    // out_ready reaches in_ready combinationally to keep full throughput.
    always_comb begin
        in_ready = '0;
        if (busy) begin
            in_ready[gidx] = out_free;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_hit) state_nxt = BURST;
            BURST:   if (xfer && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            gidx     <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else if (state == IDLE) begin
            if (sel_hit) begin
                grant    <= LEVELS'(1) << sel;
                gidx     <= sel;
                beat_cnt <= '0;
            end
        end else if (xfer) begin
            if (is_last) begin
                grant    <= '0;
                beat_cnt <= '0;
                rr_ptr   <= (gidx == LEVEL_W'(LEVELS - 1)) ? '0 : gidx + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // A new beat may replace the old one in the cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_stream <= '0;
            out_level  <= '0;
            out_last   <= 1'b0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_stream <= beat;
            out_level  <= gidx;
            out_last   <= is_last;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_stream_arbiter.sv
// Bench for window_stream_arbiter: directed scenarios plus random
// traffic checked against a packet-level round-robin model.
module tb_window_stream_arbiter;

    localparam int W  = 128;
    localparam int L  = 7;
    localparam int LW = 3;
    localparam int B  = 10;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [LW-1:0] lvl;
        logic          last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [L-1:0]   in_valid = '0;
    logic [W*L-1:0] in_stream = '0;
    logic [L-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_stream;
    logic [LW-1:0]  out_level;
    logic           out_last;
    logic           out_ready = 1'b1;
    logic [L-1:0]   grant;
    logic           busy;

    window_stream_arbiter #(
        .BUS_WIDTH(W), .LEVELS(L), .LEVEL_W(LW), .BEATS(B), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_stream(in_stream), .in_ready(in_ready),
        .out_valid(out_valid), .out_stream(out_stream),
        .out_level(out_level), .out_last(out_last), .out_ready(out_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] src_q[L][$];
    int           src_pos[L];
    int           gap[L];
    exp_t         exp_q[$];
    int           pkt_q[$];
    int           mptr;

    int           rdy_mode, rand_gap, rdy_cnt, cyc;
    int           fgap_lvl = -1, fgap_at, fgap_len;
    logic [L-1:0] prev_grant;
    bit           last_done, req_idle, hold;
    logic [W-1:0] held;
    int           outs, first_out, last_out;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int lvl, input bit rnd, input logic [W-1:0] base);
        logic [W-1:0] d;
        for (int k = 0; k < B; k++) begin
            d = rnd ? {$urandom, $urandom, $urandom, $urandom} : base + W'(k);
            src_q[lvl].push_back(d);
        end
    endtask

    // Packet-level model: serve whole queued packets in round-robin order.
    task automatic build_exp();
        int   cnt[L];
        int   off[L];
        int   s;
        exp_t e;
        for (int j = 0; j < L; j++) begin
            cnt[j] = src_q[j].size() / B;
            off[j] = 0;
        end
        while (1) begin
            s = -1;
            for (int i = 0; i < L; i++) begin
                if (s < 0 && cnt[(mptr + i) % L] > 0) s = (mptr + i) % L;
            end
            if (s < 0) break;
            pkt_q.push_back(s);
            for (int k = 0; k < B; k++) begin
                e.d    = src_q[s][off[s] + k];
                e.lvl  = LW'(s);
                e.last = (k == B - 1);
                exp_q.push_back(e);
            end
            off[s] += B;
            cnt[s]--;
            mptr = (s + 1) % L;
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 4) != 0;
            default: begin
                out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
                rdy_cnt++;
            end
        endcase
        for (int j = 0; j < L; j++) begin
            in_valid[j] = (src_q[j].size() > 0) && (gap[j] == 0);
            in_stream[j*W +: W] = (src_q[j].size() > 0) ? src_q[j][0] : '0;
            if (gap[j] > 0) gap[j]--;
        end
        #1;
        if (last_done) chk("idle_after_last", {busy, grant}, '0);
        if (req_idle) chk("grant_latency", busy, 1);
        if (grant != 0 && prev_grant == 0) begin
            if (pkt_q.size() == 0) chk("unexpected_grant", grant, '0);
            else chk("grant_order", grant, L'(1) << pkt_q.pop_front());
        end
        chk("ready_owner", in_ready & ~grant, '0);
        if (hold) begin
            chk("hold_data", out_stream, held);
            chk("hold_valid", out_valid, 1);
        end
        if (out_valid && !out_ready) begin
            chk("ready_backpressure", in_ready, '0);
            hold = 1;
            held = out_stream;
        end else begin
            hold = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_stream, e.d);
                chk("out_level", out_level, e.lvl);
                chk("out_last", out_last, e.last);
            end
            if (outs == 0) first_out = cyc;
            last_out = cyc;
            outs++;
        end
        last_done = 0;
        for (int j = 0; j < L; j++) begin
            if (in_valid[j] && in_ready[j]) begin
                void'(src_q[j].pop_front());
                src_pos[j]++;
                if (src_pos[j] % B == 0) last_done = 1;
                else if (j == fgap_lvl && src_pos[j] % B == fgap_at) gap[j] = fgap_len;
                else if (rand_gap != 0 && $urandom % 6 == 0) gap[j] = $urandom_range(1, 3);
            end
        end
        req_idle = !busy && (in_valid != 0);
        prev_grant = grant;
    endtask

    task automatic run(input int max_outs);
        int budget = 0;
        outs = 0;
        while (exp_q.size() > 0 && outs < max_outs && budget < 3000) begin
            cycle();
            budget++;
        end
        if (budget >= 3000) chk("timeout_beats_left", exp_q.size(), 0);
        if (outs < max_outs) begin
            cycle();
            cycle();
            chk("packets_left", pkt_q.size(), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        for (int j = 0; j < L; j++) begin
            src_q[j].delete();
            src_pos[j] = 0;
            gap[j] = 0;
        end
        exp_q.delete();
        pkt_q.delete();
        mptr = 0;
        last_done = 0;
        req_idle = 0;
        hold = 0;
        prev_grant = '0;
        fgap_lvl = -1;
        rdy_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_grant_busy", {busy, grant}, '0);
        chk("rst_out_regs", {out_last, out_level, out_stream}, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        rdy_mode = 0;
        rand_gap = 0;
        cyc = 0;

        // Single level 3, beats 1..10, no backpressure.
        do_reset();
        push_pkt(3, 0, 1);
        build_exp();
        run(1000);
        chk("consecutive_beats", last_out - first_out, B - 1);
        chk("beat_count", outs, B);

        // Levels 0 and 5 together from reset.
        do_reset();
        push_pkt(0, 1, 0);
        push_pkt(5, 1, 0);
        build_exp();
        run(1000);

        // All levels, two packets each.
        do_reset();
        for (int j = 0; j < L; j++) begin
            push_pkt(j, 1, 0);
            push_pkt(j, 1, 0);
        end
        build_exp();
        run(1000);

        // Output backpressure pattern 1,0,0,1.
        do_reset();
        rdy_mode = 2;
        push_pkt(1, 1, 0);
        build_exp();
        run(1000);
        rdy_mode = 0;

        // Level 2 pauses after beat 4 while level 6 waits.
        do_reset();
        fgap_lvl = 2;
        fgap_at  = 4;
        fgap_len = 5;
        push_pkt(2, 1, 0);
        push_pkt(6, 1, 0);
        build_exp();
        run(1000);
        fgap_lvl = -1;

        // Random traffic, backpressure and upstream gaps.
        do_reset();
        rdy_mode = 1;
        rand_gap = 1;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < L; j++) begin
                repeat ($urandom_range(0, 2)) push_pkt(j, 1, 0);
            end
            build_exp();
            run(100000);
        end
        rdy_mode = 0;
        rand_gap = 0;

        // Reset in the middle of a packet.
        do_reset();
        push_pkt(4, 1, 0);
        build_exp();
        run(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_grant", grant, '0);
        chk("async_busy", busy, 0);
        do_reset();
        for (int j = 0; j < L; j++) push_pkt(j, 1, 0);
        build_exp();
        run(1000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
